// File: rtl/systolic_sched.sv
// systolic_sched: buffer-driven job sequencer for the systolic array (weight load, skewed feature stream, drain)
module systolic_sched #(
  parameter int width  = 8,
  parameter int col    = 3,
  parameter int row    = 3,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             num_vec,
  input  logic [ADDR_W-1:0]      w_base,
  input  logic [ADDR_W-1:0]      f_base,
  output logic                   w_rd,
  output logic [ADDR_W-1:0]      w_addr,
  input  logic [width*col-1:0]   w_rdata,
  output logic                   f_rd,
  output logic [ADDR_W-1:0]      f_addr,
  input  logic [width*row-1:0]   f_rdata,
  output logic [width*col-1:0]   weight_out,
  output logic [width*row-1:0]   feature_out,
  output logic                   w_ps,
  output logic [col-1:0]         out_en,
  output logic                   busy,
  output logic                   done
);
  localparam int CNT_W = $clog2(2*row + col + 258);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_ROW = CNT_W'(row);
  localparam logic [CNT_W-1:0] C_OE  = CNT_W'(2*row + 2);
  localparam logic [CNT_W-1:0] C_END = CNT_W'(2*row + col + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_t;
  logic [7:0]          r_nv;
  logic [ADDR_W-1:0]   r_wb, r_fb, r_w_addr, r_f_addr;
  logic                r_busy, r_w_rd, r_f_rd, r_wv, r_fv, r_done;
  logic [col-1:0]      r_oe;

  logic                w_idle, w_acc, w_act, w_wr, w_fr;
  logic [7:0]          w_nv;
  logic [ADDR_W-1:0]   w_wb, w_fb;
  logic [CNT_W-1:0]    w_n, w_nvc, w_end;
  logic [col-1:0]      w_oe;
  logic [width*row-1:0] w_l0;

  // w_n is the job cycle number the registered outputs will present after this edge
  always_comb begin
    w_idle = r_state == S_IDLE;
    w_acc  = w_idle && start && num_vec != '0;
    w_nv   = w_idle ? num_vec : r_nv;
    w_wb   = w_idle ? w_base : r_wb;
    w_fb   = w_idle ? f_base : r_fb;
    w_nvc  = CNT_W'(w_nv);
    w_n    = w_idle ? C_ONE : r_t + C_ONE;
    w_end  = C_END + w_nvc;
    w_act  = (w_acc || !w_idle) && w_n <= w_end;
    w_wr   = w_act && w_n <= C_ROW;
    w_fr   = w_act && w_n > C_ROW && w_n <= C_ROW + w_nvc;
    w_oe   = '0;
    for (int j = 0; j < col; j++)
      w_oe[j] = w_act && w_n >= C_OE + CNT_W'(j) && w_n < C_OE + CNT_W'(j) + w_nvc;
    w_l0   = (r_fv && !rst) ? f_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_t      <= '0;
      r_nv     <= '0;
      r_wb     <= '0;
      r_fb     <= '0;
      r_busy   <= 1'b0;
      r_w_rd   <= 1'b0;
      r_w_addr <= '0;
      r_f_rd   <= 1'b0;
      r_f_addr <= '0;
      r_wv     <= 1'b0;
      r_fv     <= 1'b0;
      r_oe     <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_nv <= num_vec;
        r_wb <= w_base;
        r_fb <= f_base;
      end
      r_state  <= !w_act ? S_IDLE : w_n <= C_ROW ? S_LOAD_W : w_n <= C_ROW + w_nvc ? S_STREAM : S_DRAIN;
      r_t      <= w_act ? w_n : '0;
      r_busy   <= w_act;
      r_w_rd   <= w_wr;
      r_w_addr <= w_wr ? w_wb + ADDR_W'(w_n - C_ONE) : '0;
      r_f_rd   <= w_fr;
      r_f_addr <= w_fr ? w_fb + ADDR_W'(w_n - C_ROW - C_ONE) : '0;
      r_wv     <= r_w_rd;
      r_fv     <= r_f_rd;
      r_oe     <= w_oe;
      r_done   <= w_act && w_n == w_end;
    end
  end

  // row i of the array sees its slice of each feature vector i cycles late
  for (genvar i = 0; i < row; i++) begin : g_sk
    if (i == 0) begin : g_z
      assign feature_out[0 +: width] = w_l0[0 +: width];
    end else begin : g_d
      logic [width-1:0] r_d [i];
      always_ff @(posedge clk) begin
        if (rst) r_d <= '{default: '0};
        else begin
          r_d[0] <= w_l0[i*width +: width];
          for (int k = 1; k < i; k++) r_d[k] <= r_d[k-1];
        end
      end
      assign feature_out[i*width +: width] = rst ? '0 : r_d[i-1];
    end
  end

  assign w_rd       = r_w_rd & ~rst;
  assign w_addr     = rst ? '0 : r_w_addr;
  assign f_rd       = r_f_rd & ~rst;
  assign f_addr     = rst ? '0 : r_f_addr;
  assign w_ps       = r_wv & ~rst;
  assign weight_out = (r_wv && !rst) ? w_rdata : '0;
  assign out_en     = rst ? '0 : r_oe;
  assign busy       = r_busy & ~rst;
  assign done       = r_done & ~rst;
endmodule
